// File: rtl/divisor_multiciclo_pkg.sv
// Shared definitions for the multi-cycle divider: FSM states and default width.
package divisor_multiciclo_pkg;

  localparam int unsigned LARGURA_PADRAO = 32;

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    CALC   = 2'd1,
    AJUSTE = 2'd2,
    FIM    = 2'd3
  } estado_t;

endpackage

// File: rtl/divisor_multiciclo_passo.sv
// One restoring shift-subtract step: shifts the next dividend bit into the
// partial remainder and subtracts the divisor when it fits.
module divisor_passo
  import divisor_multiciclo_pkg::*;
#(
  parameter int unsigned LARGURA = LARGURA_PADRAO
) (
  input  logic [LARGURA-1:0] resto_i,
  input  logic               bit_i,
  input  logic [LARGURA-1:0] divisor_i,
  output logic [LARGURA-1:0] resto_o,
  output logic               q_bit_o
);

  logic [LARGURA:0] desloc;
  logic [LARGURA:0] dif;

  // Partial remainder stays below the divisor, so one extra bit holds the shift.
  always_comb begin
    desloc  = {resto_i, bit_i};
    dif     = desloc - {1'b0, divisor_i};
    q_bit_o = ~dif[LARGURA];
    resto_o = q_bit_o ? dif[LARGURA-1:0] : desloc[LARGURA-1:0];
  end

endmodule

// File: rtl/divisor_multiciclo.sv
// Multi-cycle restoring divider (div / divu) producing HI = remainder, LO = quotient.
module divisor_multiciclo
  import divisor_multiciclo_pkg::*;
#(
  parameter int unsigned LARGURA = LARGURA_PADRAO
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inicio,
  input  logic               sem_sinal,
  input  logic [LARGURA-1:0] dividendo,
  input  logic [LARGURA-1:0] divisor,
  output logic [LARGURA-1:0] hi,
  output logic [LARGURA-1:0] lo,
  output logic               ocupado,
  output logic               pronto,
  output logic               div_zero
);

  localparam int unsigned CW = (LARGURA > 1) ? $clog2(LARGURA) : 1;
  localparam logic [CW-1:0] ULTIMO = CW'(LARGURA - 1);

  estado_t            estado_q;
  logic [CW-1:0]      cont_q;
  logic [LARGURA-1:0] resto_q;
  logic [LARGURA-1:0] quoc_q;
  logic [LARGURA-1:0] dvs_q;
  logic               sem_sinal_q;
  logic               neg_dvd_q;
  logic               neg_dvs_q;
  logic [LARGURA-1:0] hi_q;
  logic [LARGURA-1:0] lo_q;
  logic               ocupado_q;
  logic               pronto_q;
  logic               div_zero_q;

  logic [LARGURA-1:0] mag_dvd;
  logic [LARGURA-1:0] mag_dvs;
  logic [LARGURA-1:0] resto_d;
  logic               q_bit;

  // Operand magnitudes; the most-negative value maps onto itself as unsigned.
  always_comb begin
    mag_dvd = (!sem_sinal && dividendo[LARGURA-1]) ? (~dividendo + LARGURA'(1)) : dividendo;
    mag_dvs = (!sem_sinal && divisor[LARGURA-1])   ? (~divisor + LARGURA'(1))   : divisor;
  end

  divisor_passo #(.LARGURA(LARGURA)) u_passo (
    .resto_i   (resto_q),
    .bit_i     (quoc_q[LARGURA-1]),
    .divisor_i (dvs_q),
    .resto_o   (resto_d),
    .q_bit_o   (q_bit)
  );

  // Control FSM with datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q    <= OCIOSO;
      cont_q      <= '0;
      resto_q     <= '0;
      quoc_q      <= '0;
      dvs_q       <= '0;
      sem_sinal_q <= 1'b0;
      neg_dvd_q   <= 1'b0;
      neg_dvs_q   <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      ocupado_q   <= 1'b0;
      pronto_q    <= 1'b0;
      div_zero_q  <= 1'b0;
    end else begin
      case (estado_q)
        OCIOSO: begin
          if (inicio) begin
            sem_sinal_q <= sem_sinal;
            neg_dvd_q   <= dividendo[LARGURA-1];
            neg_dvs_q   <= divisor[LARGURA-1];
            resto_q     <= '0;
            quoc_q      <= mag_dvd;
            dvs_q       <= mag_dvs;
            cont_q      <= '0;
            div_zero_q  <= 1'b0;
            ocupado_q   <= 1'b1;
            if (divisor == '0) begin
              hi_q       <= dividendo;
              lo_q       <= '1;
              div_zero_q <= 1'b1;
              pronto_q   <= 1'b1;
              estado_q   <= FIM;
            end else begin
              estado_q <= CALC;
            end
          end
        end
        CALC: begin
          resto_q <= resto_d;
          quoc_q  <= {quoc_q[LARGURA-2:0], q_bit};
          if (cont_q == ULTIMO) begin
            cont_q   <= '0;
            estado_q <= AJUSTE;
          end else begin
            cont_q <= cont_q + CW'(1);
          end
        end
        AJUSTE: begin
          // Signed results: quotient negated on differing signs, remainder follows dividend.
          if (!sem_sinal_q && (neg_dvd_q ^ neg_dvs_q)) lo_q <= ~quoc_q + LARGURA'(1);
          else                                         lo_q <= quoc_q;
          if (!sem_sinal_q && neg_dvd_q) hi_q <= ~resto_q + LARGURA'(1);
          else                           hi_q <= resto_q;
          pronto_q <= 1'b1;
          estado_q <= FIM;
        end
        FIM: begin
          pronto_q  <= 1'b0;
          ocupado_q <= 1'b0;
          estado_q  <= OCIOSO;
        end
        default: begin
          estado_q  <= OCIOSO;
          pronto_q  <= 1'b0;
          ocupado_q <= 1'b0;
        end
      endcase
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign ocupado  = ocupado_q;
  assign pronto   = pronto_q;
  assign div_zero = div_zero_q;

endmodule

// File: tb/tb_divisor_multiciclo.sv
// Directed self-checking bench for divisor_multiciclo with a result scoreboard.
module tb_divisor_multiciclo;

  localparam int unsigned W = 32;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    logic [7:0]   lat;
  } esperado_t;

  logic         clk = 1'b0;
  logic         reset, inicio, sem_sinal;
  logic [W-1:0] dividendo, divisor;
  logic [W-1:0] hi, lo;
  logic         ocupado, pronto, div_zero;

  int vetores = 0;
  int erros   = 0;
  esperado_t fila[$];

  always #5 clk = ~clk;

  divisor_multiciclo #(.LARGURA(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .inicio    (inicio),
    .sem_sinal (sem_sinal),
    .dividendo (dividendo),
    .divisor   (divisor),
    .hi        (hi),
    .lo        (lo),
    .ocupado   (ocupado),
    .pronto    (pronto),
    .div_zero  (div_zero)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vetores++;
    assert (obs === exp) else begin
      erros++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic esperado_t modelo(input logic [W-1:0] a, input logic [W-1:0] b, input logic u);
    esperado_t e;
    e.dz  = 1'b0;
    e.lat = 8'(W + 2);
    if (b == '0) begin
      e.hi = a; e.lo = '1; e.dz = 1'b1; e.lat = 8'd1;
    end else if (u) begin
      e.hi = a % b; e.lo = a / b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.hi = '0; e.lo = 32'h8000_0000;
    end else begin
      e.hi = W'($signed(a) % $signed(b));
      e.lo = W'($signed(a) / $signed(b));
    end
    return e;
  endfunction

  // Starts one division; optionally pokes inicio while busy, then checks result and timing.
  task automatic dividir(input logic [W-1:0] a, input logic [W-1:0] b, input logic u, input bit cutucar);
    esperado_t e;
    int lat;
    @(negedge clk);
    inicio = 1'b1; sem_sinal = u; dividendo = a; divisor = b;
    fila.push_back(modelo(a, b, u));
    @(posedge clk); #1;
    inicio = 1'b0; dividendo = 32'hDEAD_BEEF; divisor = 32'h3; sem_sinal = ~u;
    lat = 1;
    while (!pronto && lat < 100) begin
      if (cutucar && lat == 5) inicio = 1'b1;
      @(posedge clk); #1;
      inicio = 1'b0;
      lat++;
    end
    e = fila.pop_front();
    check("latencia", W'(lat), W'(e.lat));
    check("pronto", W'(pronto), W'(1));
    check("ocupado_fim", W'(ocupado), W'(1));
    check("hi", hi, e.hi);
    check("lo", lo, e.lo);
    check("div_zero", W'(div_zero), W'(e.dz));
    // inicio during the pronto cycle must be ignored
    inicio = 1'b1; divisor = 32'h5;
    @(posedge clk); #1;
    inicio = 1'b0;
    check("pronto_pulso", W'(pronto), W'(0));
    check("ocupado_ocioso", W'(ocupado), W'(0));
    check("hi_mantido", hi, e.hi);
    check("lo_mantido", lo, e.lo);
    check("dz_mantido", W'(div_zero), W'(e.dz));
    @(posedge clk); #1;
    check("ignora_no_pronto", W'(ocupado), W'(0));
  endtask

  initial begin
    bit viu_pronto;
    reset = 1'b1; inicio = 1'b0; sem_sinal = 1'b1; dividendo = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hi", hi, '0);
    check("rst_lo", lo, '0);
    check("rst_ocupado", W'(ocupado), W'(0));
    check("rst_pronto", W'(pronto), W'(0));
    check("rst_dz", W'(div_zero), W'(0));
    reset = 1'b0;

    dividir(32'd100, 32'd7, 1'b1, 1'b0);
    dividir(32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    dividir(32'h0000_1234, 32'd0, 1'b1, 1'b0);
    dividir(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    dividir(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
    dividir(32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0);
    dividir(32'hFFFF_FFC4, 32'hFFFF_FFF9, 1'b0, 1'b0);
    dividir(32'd3, 32'd10, 1'b1, 1'b0);
    dividir(32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0);
    dividir(32'h8000_0000, 32'd0, 1'b0, 1'b0);
    dividir(32'd100, 32'd7, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++)
      dividir(W'($urandom), W'($urandom_range(1, 1000)), 1'(i % 2), 1'b0);

    // Reset during CALC aborts the operation with no pronto
    @(negedge clk);
    inicio = 1'b1; sem_sinal = 1'b1; dividendo = 32'd1000; divisor = 32'd3;
    @(posedge clk); #1;
    inicio = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_ocupado", W'(ocupado), W'(0));
    check("abort_hi", hi, '0);
    check("abort_lo", lo, '0);
    check("abort_pronto", W'(pronto), W'(0));
    viu_pronto = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (pronto) viu_pronto = 1'b1;
    end
    check("abort_sem_pronto", W'(viu_pronto), W'(0));

    dividir(32'd100, 32'd7, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vetores, erros);
    $finish;
  end

endmodule

// File: doc/divisor_multiciclo.md
DIVISOR_MULTICICLO -- requirements
Module: divisor_multiciclo

Interface
REQ-001 SHALL have parameter LARGURA, default 32, operand and result width in bits.
REQ-002 SHALL have clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have inicio  input  1  start request, sampled only in OCIOSO.
REQ-005 SHALL have sem_sinal  input  1  1 = divu (unsigned), 0 = div (two's complement).
REQ-006 SHALL have dividendo  input  LARGURA  numerator, captured with inicio.
REQ-007 SHALL have divisor  input  LARGURA  denominator, captured with inicio.
REQ-008 SHALL have hi  output  LARGURA  remainder, feeding a HI input of the downstream 8-input write-data mux.
REQ-009 SHALL have lo  output  LARGURA  quotient, feeding a LO input of the downstream 8-input write-data mux.
REQ-010 SHALL have ocupado  output  1  high while a division is in progress.
REQ-011 SHALL have pronto  output  1  one-cycle pulse marking hi/lo valid.
REQ-012 SHALL have div_zero  output  1  set with pronto when divisor was zero; held until next accepted start.

Function
REQ-013 SHALL implement FSM states OCIOSO, CALC, AJUSTE, FIM.
REQ-014 OCIOSO: inicio=1 at an edge SHALL capture operands and sem_sinal, clear div_zero, go to CALC (divisor nonzero) or FIM (divisor zero).
REQ-015 CALC SHALL perform one restoring shift-subtract step per cycle on operand magnitudes for exactly LARGURA cycles, tracked by a step counter counting 0..LARGURA-1, then go to AJUSTE.
REQ-016 AJUSTE SHALL apply signs when sem_sinal=0: quotient negated if operand signs differ; remainder takes dividend sign; then go to FIM.
REQ-017 FIM SHALL update hi/lo, assert pronto for exactly one cycle, return to OCIOSO.
REQ-018 Latency SHALL be LARGURA+2 cycles from accepting edge to pronto-high cycle (34 for LARGURA=32); divide-by-zero latency SHALL be 1 cycle.
REQ-019 ocupado SHALL be high in CALC, AJUSTE, FIM; low in OCIOSO.
REQ-020 inicio while ocupado=1 SHALL be ignored, with no effect on the current operation.
REQ-021 hi/lo SHALL change only in FIM or on reset, holding their values between operations.
REQ-022 Divide-by-zero SHALL yield hi=dividendo, lo=all ones, div_zero=1.
REQ-023 Signed overflow (most-negative / -1) SHALL yield lo=most-negative value, hi=0, div_zero=0.
REQ-024 Magnitude of the most-negative signed operand SHALL be computed as LARGURA-bit unsigned (no width extension needed).
REQ-025 inicio in the same cycle as pronto SHALL be ignored (FSM not yet in OCIOSO).

Reset
REQ-026 reset=1 at an edge SHALL force OCIOSO, hi=0, lo=0, pronto=0, div_zero=0, counter=0, from any state.
REQ-027 reset SHALL take priority over inicio; an aborted division SHALL produce no pronto.

Structure
REQ-028 State enum and default LARGURA constant SHALL reside in the shared project package.
REQ-029 One combinational sub-module, divisor_passo, SHALL implement a single shift-subtract step (partial remainder, quotient bit).

Verification
REQ-030 Unsigned: dividendo=100, divisor=7, sem_sinal=1 -> pronto at cycle 34, lo=14, hi=2, div_zero=0.
REQ-031 Signed: dividendo=-7 (0xFFFFFFF9), divisor=2, sem_sinal=0 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
REQ-032 Zero divisor: dividendo=0x1234, divisor=0 -> pronto 1 cycle after start, hi=0x1234, lo=0xFFFFFFFF, div_zero=1.
REQ-033 Overflow: dividendo=0x80000000, divisor=0xFFFFFFFF, signed -> lo=0x80000000, hi=0.
REQ-034 Reset at cycle 10 of CALC -> next cycle OCIOSO, ocupado=0, hi=lo=0, no pronto; inicio asserted at cycle 5 of a division -> ignored, result unchanged.
